// File: rtl/uart_tx_drain_ctrl_pkg.sv
// Shared types and constants for the UART transmit drain controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    LOAD     = 3'd3,
    BACKOFF  = 3'd4
  } drain_state_t;

  localparam int UART_BYTE_W = 8;
  localparam int RETRY_DELAY = 4;

endpackage

// File: rtl/uart_tx_drain_ctrl_if.sv
// Ring-buffer read port plus transmitter byte handshake.
// Latency: n/a (wiring only).
// Backpressure: txReady stalls txValid/txData; the buffer side has none.
interface uart_tx_drain_ctrl_if;
  import uart_pkg::*;

  logic                   bufReadEnable;
  logic                   bufReadAck;
  logic [UART_BYTE_W-1:0] bufReadData;
  logic                   txValid;
  logic [UART_BYTE_W-1:0] txData;
  logic                   txReady;

  // Drain controller side
  modport master (
    output bufReadEnable,
    input  bufReadAck,
    input  bufReadData,
    output txValid,
    output txData,
    input  txReady
  );

  // Buffer / transmitter side
  modport slave (
    input  bufReadEnable,
    output bufReadAck,
    output bufReadData,
    input  txValid,
    input  txData,
    output txReady
  );
endinterface

// File: rtl/uart_tx_drain_ctrl_retry_timer.sv
// Loadable down-counter timing the empty-buffer backoff.
// Latency: done reflects the registered count in the same cycle.
// Backpressure: none; counts down only while dec is high and stops at zero.
module uart_retry_timer #(
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [Width-1:0] count;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - Width'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/uart_tx_drain_ctrl.sv
// Pops ring-buffer bytes one at a time and hands them to the UART transmitter.
// Latency: 3 cycles per byte (REQ, WAIT_ACK, LOAD) with txReady held high.
// Backpressure: txReady low holds the byte in LOAD; an empty read backs off RetryDelay cycles.
module uart_tx_drain_ctrl
  import uart_pkg::*;
#(
  parameter int RetryDelay = RETRY_DELAY,
  parameter int CountBits  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  uart_tx_drain_ctrl_if.master bus,
  output logic                 busy,
  output logic [CountBits-1:0] bytesSent,
  output logic                 emptyRetry
);

  // Counter only ever holds RetryDelay-1, so clog2 bits suffice (min 1 bit)
  localparam int TimerW = (RetryDelay > 1) ? $clog2(RetryDelay) : 1;
  localparam logic [TimerW-1:0] BackoffLoad = TimerW'(RetryDelay - 1);

  drain_state_t state;
  logic         timer_load;
  logic         timer_dec;
  logic         timer_done;

  // Ack is only sampled in WAIT_ACK; any other level is the buffer's held value
  assign timer_load = (state == WAIT_ACK) && !bus.bufReadAck;
  assign timer_dec  = (state == BACKOFF);

  uart_retry_timer #(
    .Width(TimerW)
  ) u_retry_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (BackoffLoad),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  // Drain FSM; every output is registered and updated alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      bus.bufReadEnable <= 1'b0;
      bus.txValid       <= 1'b0;
      bus.txData        <= '0;
      busy              <= 1'b0;
      bytesSent         <= '0;
      emptyRetry        <= 1'b0;
    end else begin
      // Read request and retry flag are single-cycle pulses
      bus.bufReadEnable <= 1'b0;
      emptyRetry        <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state             <= REQ;
            bus.bufReadEnable <= 1'b1;
            busy              <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.bufReadAck) begin
            // A popped byte is always delivered, even if enable has dropped
            bus.txData  <= bus.bufReadData;
            bus.txValid <= 1'b1;
            state       <= LOAD;
          end else begin
            emptyRetry <= 1'b1;
            state      <= BACKOFF;
          end
        end
        LOAD: begin
          if (bus.txReady) begin
            bus.txValid <= 1'b0;
            bytesSent   <= bytesSent + CountBits'(1);
            if (enable) begin
              state             <= REQ;
              bus.bufReadEnable <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        BACKOFF: begin
          if (timer_done) begin
            if (enable) begin
              state             <= REQ;
              bus.bufReadEnable <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain_ctrl.sv
// Directed bench for uart_tx_drain_ctrl with a small ring-buffer model.
// Latency: n/a.
// Backpressure: txReady is driven directly by the stimulus.
module tb_uart_tx_drain_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        busy;
  logic [15:0] bytesSent;
  logic        emptyRetry;

  // Ring buffer model controls
  logic        wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  q[$];

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int er_cnt = 0;
  int tv_cnt = 0;
  logic prev_rd = 1'b0;

  uart_tx_drain_ctrl_if bus ();

  uart_tx_drain_ctrl #(
    .RetryDelay (4),
    .CountBits  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus.master),
    .busy       (busy),
    .bytesSent  (bytesSent),
    .emptyRetry (emptyRetry)
  );

  always #5 clk = ~clk;

  // Buffer: registered, level-held ack; a same-edge write beats the read
  always @(posedge clk) begin
    if (bus.bufReadEnable) begin
      if (wr) begin
        q.push_back(wdata);
        bus.bufReadAck <= 1'b0;
      end else if (q.size() == 0) begin
        bus.bufReadAck <= 1'b0;
      end else begin
        bus.bufReadAck  <= 1'b1;
        bus.bufReadData <= q.pop_front();
      end
    end else begin
      if (wr) q.push_back(wdata);
      if (reset) begin
        bus.bufReadAck  <= 1'b0;
        bus.bufReadData <= 8'h00;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, keep pulse tallies
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rd_not_back_to_back", {31'd0, prev_rd & bus.bufReadEnable}, 32'd0);
    prev_rd = bus.bufReadEnable;
    if (bus.bufReadEnable === 1'b1) rd_cnt++;
    if (emptyRetry === 1'b1) er_cnt++;
    if (bus.txValid === 1'b1) tv_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd"}, {31'd0, bus.bufReadEnable}, 32'd0);
    chk({tag, "_txvalid"}, {31'd0, bus.txValid}, 32'd0);
    chk({tag, "_txdata"}, {24'd0, bus.txData}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_bytes"}, {16'd0, bytesSent}, 32'd0);
    chk({tag, "_retry"}, {31'd0, emptyRetry}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41;
    exp_b[1] = 8'h42;
    exp_b[2] = 8'h43;
    bus.txReady = 1'b1;

    // Preload the buffer while reset is held
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      wdata = exp_b[i];
      tick();
    end
    wr = 1'b0;
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_disabled_busy", {31'd0, busy}, 32'd0);

    // Test 1: three bytes, 3 cycles apart, then an empty read
    enable = 1'b1;
    tick();
    chk("t1_first_req", {31'd0, bus.bufReadEnable}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_wait_txvalid", {31'd0, bus.txValid}, 32'd0);
      tick();
      chk("t1_txvalid", {31'd0, bus.txValid}, 32'd1);
      chk("t1_txdata", {24'd0, bus.txData}, {24'd0, exp_b[i]});
      tick();
      chk("t1_txvalid_drop", {31'd0, bus.txValid}, 32'd0);
      chk("t1_bytes", {16'd0, bytesSent}, i + 1);
      chk("t1_next_req", {31'd0, bus.bufReadEnable}, 32'd1);
    end
    tick();
    tick();
    chk("t1_empty_retry", {31'd0, emptyRetry}, 32'd1);
    chk("t1_busy_backoff", {31'd0, busy}, 32'd1);
    chk("t1_rd_count", rd_cnt, 32'd4);

    // Test 2: empty buffer, a read every 6 cycles
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("t2_backoff_no_rd", {31'd0, bus.bufReadEnable}, 32'd0);
      end
      tick();
      chk("t2_retry_req", {31'd0, bus.bufReadEnable}, 32'd1);
      tick();
      tick();
      chk("t2_retry_pulse", {31'd0, emptyRetry}, 32'd1);
    end
    chk("t2_rd_count", rd_cnt, 32'd7);
    chk("t2_retry_count", er_cnt, 32'd4);
    chk("t2_no_txvalid", tv_cnt, 32'd3);

    // Test 3: write collides with the read cycle, next read returns it
    for (int j = 0; j < 3; j++) tick();
    tick();
    chk("t3_req", {31'd0, bus.bufReadEnable}, 32'd1);
    wr = 1'b1;
    wdata = 8'h55;
    tick();
    wr = 1'b0;
    tick();
    chk("t3_collision_retry", {31'd0, emptyRetry}, 32'd1);
    chk("t3_collision_no_tx", {31'd0, bus.txValid}, 32'd0);
    for (int j = 0; j < 3; j++) tick();
    tick();
    chk("t3_rereq", {31'd0, bus.bufReadEnable}, 32'd1);
    tick();
    wr = 1'b1;
    wdata = 8'h7E;
    tick();
    wr = 1'b0;
    chk("t3_txvalid", {31'd0, bus.txValid}, 32'd1);
    chk("t3_txdata", {24'd0, bus.txData}, 32'h55);
    tick();
    chk("t3_bytes", {16'd0, bytesSent}, 32'd4);

    // Test 4: transmitter stalls for 10 cycles on 0x7E
    bus.txReady = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      wr = (i == 0);
      wdata = 8'h10;
      chk("t4_hold_valid", {31'd0, bus.txValid}, 32'd1);
      chk("t4_hold_data", {24'd0, bus.txData}, 32'h7E);
      chk("t4_hold_no_rd", {31'd0, bus.bufReadEnable}, 32'd0);
      if (i < 9) tick();
    end
    wr = 1'b0;
    chk("t4_rd_count", rd_cnt, 32'd10);
    bus.txReady = 1'b1;
    tick();
    chk("t4_accept_valid", {31'd0, bus.txValid}, 32'd0);
    chk("t4_accept_bytes", {16'd0, bytesSent}, 32'd5);
    chk("t4_accept_req", {31'd0, bus.bufReadEnable}, 32'd1);

    // Test 5: enable drops during WAIT_ACK, the byte still goes out
    tick();
    enable = 1'b0;
    tick();
    chk("t5_txvalid", {31'd0, bus.txValid}, 32'd1);
    chk("t5_txdata", {24'd0, bus.txData}, 32'h10);
    tick();
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_bytes", {16'd0, bytesSent}, 32'd6);
    for (int j = 0; j < 8; j++) tick();
    chk("t5_no_more_rd", rd_cnt, 32'd11);
    chk("t5_still_idle", {31'd0, busy}, 32'd0);

    // Test 6: asynchronous reset mid-LOAD, then resume
    wr = 1'b1;
    wdata = 8'h66;
    tick();
    wr = 1'b0;
    bus.txReady = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_load_valid", {31'd0, bus.txValid}, 32'd1);
    chk("t6_load_data", {24'd0, bus.txData}, 32'h66);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t6_async_reset");
    wr = 1'b1;
    wdata = 8'h77;
    @(posedge clk);
    #1;
    wr = 1'b0;
    prev_rd = 1'b0;
    #2;
    reset = 1'b0;
    bus.txReady = 1'b1;
    tick();
    chk("t6_resume_req", {31'd0, bus.bufReadEnable}, 32'd1);
    tick();
    tick();
    chk("t6_resume_valid", {31'd0, bus.txValid}, 32'd1);
    chk("t6_resume_data", {24'd0, bus.txData}, 32'h77);
    tick();
    chk("t6_resume_bytes", {16'd0, bytesSent}, 32'd1);
    enable = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain_ctrl.md
Name: uart_tx_drain_ctrl

Overview:
- Sequences the read side of the UART ring buffer. Pulls bytes one at a time and hands each to the UART transmitter over a valid/ready handshake.
- Sits between the ring buffer's read port (read enable / read ack / read data) and the TX serializer.
- Retries with a fixed backoff when the buffer is empty, or when a buffer write collides with a read and wins priority.

Parameters:
- RetryDelay, 4, idle cycles spent in BACKOFF before re-issuing a read (minimum 1).
- CountBits, 16, width of the sent-byte counter.

Ports:
- clk  input  1  global clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  drain enable from the CPU control register.
- bufReadEnable  output  1  single-cycle read request to the ring buffer.
- bufReadAck  input  1  ring buffer read acknowledge; registered and level-held by the buffer.
- bufReadData  input  8  ring buffer read data.
- txValid  output  1  byte valid toward the transmitter.
- txData  output  8  byte toward the transmitter.
- txReady  input  1  transmitter accepts txData when txValid & txReady at posedge.
- busy  output  1  high in any state other than IDLE.
- bytesSent  output  CountBits  count of bytes accepted by the transmitter; wraps.
- emptyRetry  output  1  one-cycle pulse each time a read returns no data.

Behaviour:
- Reset (async, any state): state=IDLE; bufReadEnable=0, txValid=0, txData=0, busy=0, bytesSent=0, emptyRetry=0, backoff count=0. A byte held in LOAD is discarded.
- All outputs are registered.
- IDLE: if enable=1, go to REQ next cycle.
- REQ: bufReadEnable=1 for exactly this one cycle. Next state is WAIT_ACK. bufReadEnable is never high for two consecutive cycles, because the buffer would pop twice.
- WAIT_ACK: bufReadAck is meaningful only in the cycle immediately after REQ. The buffer holds ack at 1 across idle cycles, so its level at any other time is ignored.
  - bufReadAck=1: capture bufReadData into txData, set txValid=1, go to LOAD.
  - bufReadAck=0 (buffer empty, or a simultaneous buffer write took priority and the read was dropped): pulse emptyRetry, load the backoff count with RetryDelay-1, go to BACKOFF.
- LOAD: hold txValid and txData stable until txReady=1 at a posedge. On that edge:
  - txValid=0 and bytesSent+1 (wraps from 2^CountBits-1 to 0).
  - Next state is REQ if enable=1, otherwise IDLE.
  - Back-to-back throughput is one byte per 3 cycles when txReady is held high.
- BACKOFF: decrement the count each cycle. When the count reaches 0, go to REQ if enable=1, otherwise IDLE. With RetryDelay=4, a re-request is issued 4 cycles after WAIT_ACK.
- Deasserting enable:
  - In REQ or WAIT_ACK: the outstanding read completes. An acked byte is still delivered through LOAD (bytes are never dropped once popped), then the block returns to IDLE.
  - In BACKOFF: the block exits to IDLE at expiry.
- txReady asserted while txValid=0 is ignored.
- busy is 0 only in IDLE.

Decomposition:
- Package uart_pkg:
  - state enum drain_state_t {IDLE, REQ, WAIT_ACK, LOAD, BACKOFF}, 3 bits.
  - constant UART_BYTE_W=8.
  - default RETRY_DELAY=4.
- One natural sub-module, uart_retry_timer: a loadable down-counter with a done flag, used for BACKOFF. Everything else lives inline in the FSM.

Test Plan:
1. Buffer preloaded with 0x41,0x42,0x43; enable=1; txReady tied 1 -> txData sequence 0x41,0x42,0x43 with txValid high one cycle each, 3 cycles apart. bytesSent=3. Fourth read gets ack=0, and emptyRetry pulses.
2. Empty buffer, enable=1, RetryDelay=4 -> bufReadEnable pulses every 6 cycles (REQ, WAIT_ACK, 4×BACKOFF). emptyRetry pulses each time. txValid never rises.
3. A buffer write (0x55) coincides with the REQ cycle on an empty buffer -> ack=0 and retry. The next REQ returns 0x55 on txData.
4. txReady held 0 for 10 cycles during LOAD with 0x7E -> txValid and txData=0x7E stable for all 10 cycles. One read pulse only, with no extra bufReadEnable. Accepted on the first txReady=1.
5. enable dropped during WAIT_ACK with ack=1, byte 0x10 -> 0x10 still delivered, then IDLE with busy=0. No further bufReadEnable.
6. reset asserted mid-LOAD (asynchronously, not clock-aligned) -> all outputs 0 immediately, state IDLE. bytesSent returns to 0. Operation resumes after release with enable=1.
